// File: rtl/clock_div_prog.sv
// -----------------------------------------------------------------------------
// clock_div_prog
//
// Runtime-programmable clock divider. Divides clk_in by any integer N >= 2,
// even or odd, and keeps a 50% duty cycle. For odd N a negedge-sampled copy of
// the high-phase flag trims the high time to exactly N/2 clk_in periods.
// A new divisor is held as pending and only takes over at a period boundary,
// so clk_out never produces a runt pulse.
//
// Ports
//   clk_in        in   1      source clock (posedge logic, one negedge register)
//   rst           in   1      synchronous, active-high reset
//   div_in        in   WIDTH  requested divisor N
//   div_load      in   1      single-cycle request to load div_in
//   clk_out       out  1      divided clock, 50% duty
//   strobe        out  1      high for the first clk_in cycle of each period
//   period_count  out  8      number of clk_out periods started, wraps
//   div_active    out  WIDTH  divisor currently in effect
//   div_pending   out  1      a loaded divisor waits for the next boundary
//   cfg_err       out  1      one-cycle pulse for a load of 0 or 1
// -----------------------------------------------------------------------------
module clock_div_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             clk_out,
   output logic             strobe,
   output logic [7:0]       period_count,
   output logic [WIDTH-1:0] div_active,
   output logic             div_pending,
   output logic             cfg_err
);

   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(DEFAULT_DIV - 1);
   localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
   localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
   localparam logic [7:0]       ONE_8   = 8'd1;

   // Number of posedge cycles pos_q stays high for divisor n: ceil(n/2).
   // Computed one bit wider so n = 2^WIDTH-1 does not overflow.
   function automatic logic [WIDTH:0] high_len(input logic [WIDTH-1:0] n);
      logic [WIDTH:0] sum;
      sum = {1'b0, n} + {{WIDTH{1'b0}}, 1'b1};
      return sum >> 1;
   endfunction

   // A divisor is usable only if it is at least 2.
   function automatic logic div_legal(input logic [WIDTH-1:0] n);
      return (n >= DIV_MIN);
   endfunction

   // State registers
   logic [WIDTH-1:0] cnt_q,        cnt_d;
   logic             pos_q,        pos_d;
   logic             neg_q;
   logic             strobe_q,     strobe_d;
   logic [7:0]       period_q,     period_d;
   logic [WIDTH-1:0] div_active_q, div_active_d;
   logic [WIDTH-1:0] pend_div_q,   pend_div_d;
   logic             pend_vld_q,   pend_vld_d;
   logic             cfg_err_q,    cfg_err_d;

   // Combinational helpers
   logic             last_s;
   logic [WIDTH-1:0] k_s;
   logic             swap_s;
   logic [WIDTH-1:0] n_next_s;
   logic             load_ok_s;
   logic             load_bad_s;
   logic             clk_out_s;

   // Next-state logic: counter wrap, boundary divisor swap, load capture.
   always_comb begin
      last_s       = 1'b0;
      k_s          = '0;
      swap_s       = 1'b0;
      n_next_s     = div_active_q;
      load_ok_s    = 1'b0;
      load_bad_s   = 1'b0;
      cnt_d        = cnt_q;
      pos_d        = pos_q;
      strobe_d     = 1'b0;
      period_d     = period_q;
      div_active_d = div_active_q;
      pend_div_d   = pend_div_q;
      pend_vld_d   = pend_vld_q;
      cfg_err_d    = 1'b0;

      // cnt never exceeds div_active-1, so cnt+1 cannot wrap to zero;
      // k == 0 therefore happens only on the wrap and marks the boundary.
      last_s = (cnt_q == (div_active_q - ONE_W));
      if (last_s) begin
         k_s = '0;
      end else begin
         k_s = cnt_q + ONE_W;
      end

      // The pending divisor is compared with the registered flag, so a
      // load captured on this very boundary waits for the next one.
      swap_s = last_s & pend_vld_q;
      if (swap_s) begin
         n_next_s = pend_div_q;
      end else begin
         n_next_s = div_active_q;
      end

      load_ok_s  = div_load & div_legal(div_in);
      load_bad_s = div_load & ~div_legal(div_in);

      cnt_d        = k_s;
      pos_d        = ({1'b0, k_s} < high_len(n_next_s));
      strobe_d     = last_s;
      div_active_d = n_next_s;
      cfg_err_d    = load_bad_s;

      if (last_s) begin
         period_d = period_q + ONE_8;
      end else begin
         period_d = period_q;
      end

      if (load_ok_s) begin
         pend_div_d = div_in;
      end else begin
         pend_div_d = pend_div_q;
      end

      // A new legal load wins over the swap clearing the flag.
      if (load_ok_s) begin
         pend_vld_d = 1'b1;
      end else if (swap_s) begin
         pend_vld_d = 1'b0;
      end else begin
         pend_vld_d = pend_vld_q;
      end
   end

   // Posedge state update with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt_q        <= CNT_RST;
         pos_q        <= 1'b0;
         strobe_q     <= 1'b0;
         period_q     <= 8'd0;
         div_active_q <= DIV_RST;
         pend_div_q   <= DIV_RST;
         pend_vld_q   <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         pos_q        <= pos_d;
         strobe_q     <= strobe_d;
         period_q     <= period_d;
         div_active_q <= div_active_d;
         pend_div_q   <= pend_div_d;
         pend_vld_q   <= pend_vld_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   // Half-cycle delayed copy of the high-phase flag for odd divisors.
   always_ff @(negedge clk_in) begin
      if (rst) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= pos_q;
      end
   end

   // Output clock select. div_active_q updates on the same edge as pos_q
   // for the period being entered, so the mode always matches the phase
   // and only registered state reaches clk_out.
   always_comb begin
      clk_out_s = 1'b0;
      if (div_active_q[0]) begin
         clk_out_s = pos_q & neg_q;
      end else begin
         clk_out_s = pos_q;
      end
   end

   assign clk_out      = clk_out_s;
   assign strobe       = strobe_q;
   assign period_count = period_q;
   assign div_active   = div_active_q;
   assign div_pending  = pend_vld_q;
   assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_clock_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clock_div_prog
//
// Directed bench for clock_div_prog (WIDTH=8, DEFAULT_DIV=4). Inputs change
// 1 time unit after posedge; outputs are sampled 1 time unit after an edge.
// -----------------------------------------------------------------------------
module tb_clock_div_prog;

   logic       clk_in;
   logic       rst;
   logic [7:0] div_in;
   logic       div_load;
   logic       clk_out;
   logic       strobe;
   logic [7:0] period_count;
   logic [7:0] div_active;
   logic       div_pending;
   logic       cfg_err;

   int n_tests;
   int n_fail;

   clock_div_prog #(
      .WIDTH       (8),
      .DEFAULT_DIV (4)
   ) dut (
      .clk_in       (clk_in),
      .rst          (rst),
      .div_in       (div_in),
      .div_load     (div_load),
      .clk_out      (clk_out),
      .strobe       (strobe),
      .period_count (period_count),
      .div_active   (div_active),
      .div_pending  (div_pending),
      .cfg_err      (cfg_err)
   );

   // 10-unit source clock.
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // Hard stop in case a wait runs away.
   initial begin
      #1500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      div_in   = v;
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
      div_in   = 8'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Tick until strobe is seen; n returns the number of edges taken.
   task automatic wait_boundary(input string tag, input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while ((strobe !== 1'b1) && (n < budget));
      if (strobe !== 1'b1) begin
         check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      end
   endtask

   initial begin
      int n;
      int highs;
      int first_low;
      int good;
      int wrapped;
      logic [7:0] pc0;
      logic [7:0] prev;

      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b1;
      div_in   = 8'd0;
      div_load = 1'b0;

      // ---------------- reset default ----------------
      tick();
      tick();
      tick();
      check_eq("rst_clk_out",     clk_out,      0);
      check_eq("rst_strobe",      strobe,       0);
      check_eq("rst_period",      period_count, 0);
      check_eq("rst_div_active",  div_active,   4);
      check_eq("rst_div_pending", div_pending,  0);
      check_eq("rst_cfg_err",     cfg_err,      0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_eq("div4_clk_out", clk_out, ((i % 4) < 2) ? 1 : 0);
         check_eq("div4_strobe",  strobe,  ((i % 4) == 0) ? 1 : 0);
      end
      check_eq("div4_period_20", period_count, 5);

      // ---------------- odd 50% ----------------
      // Capture edge is itself a boundary, so the swap is one period later.
      do_load(8'd5);
      check_eq("odd_pending_set", div_pending, 1);
      check_eq("odd_active_old",  div_active,  4);
      wait_boundary("odd_swap", 20, n);
      check_eq("odd_swap_edges",  n,           4);
      check_eq("odd_active_new",  div_active,  5);
      check_eq("odd_pending_clr", div_pending, 0);
      check_eq("odd_low_at_pos",  clk_out,     0);
      for (int h = 0; h < 10; h++) begin
         if ((h % 2) == 0) begin
            @(negedge clk_in);
         end else begin
            @(posedge clk_in);
         end
         #1;
         check_eq("odd_half", clk_out, (h < 5) ? 1 : 0);
      end
      check_eq("odd_strobe_next", strobe, 1);
      wait_boundary("odd_period", 20, n);
      check_eq("odd_period_edges", n, 5);

      // ---------------- deferred swap ----------------
      do_reset();
      tick();
      check_eq("def_first_strobe", strobe,  1);
      check_eq("def_first_clk",    clk_out, 1);
      do_load(8'd6);
      check_eq("def_pending_k1", div_pending, 1);
      check_eq("def_active_k1",  div_active,  4);
      tick();
      check_eq("def_pending_k2", div_pending, 1);
      check_eq("def_clk_k2",     clk_out,     0);
      tick();
      check_eq("def_pending_k3", div_pending, 1);
      check_eq("def_strobe_k3",  strobe,      0);
      tick();
      check_eq("def_swap_strobe",  strobe,      1);
      check_eq("def_swap_active",  div_active,  6);
      check_eq("def_swap_pending", div_pending, 0);
      check_eq("def_swap_clk",     clk_out,     1);
      for (int j = 1; j < 6; j++) begin
         tick();
         check_eq("div6_clk_out", clk_out, (j < 3) ? 1 : 0);
         check_eq("div6_strobe",  strobe,  0);
      end
      tick();
      check_eq("div6_next_strobe", strobe, 1);

      // ---------------- last-wins / illegal ----------------
      do_load(8'd7);
      do_load(8'd3);
      check_eq("lw_pending", div_pending, 1);
      check_eq("lw_active",  div_active,  6);
      do_load(8'd1);
      check_eq("ill_cfg_err",     cfg_err,     1);
      check_eq("ill_pending_kept", div_pending, 1);
      check_eq("ill_active_kept", div_active,  6);
      tick();
      check_eq("ill_cfg_err_pulse", cfg_err, 0);
      wait_boundary("lw_swap", 20, n);
      check_eq("lw_swap_edges", n,           2);
      check_eq("lw_active_3",   div_active,  3);
      check_eq("lw_pending_0",  div_pending, 0);
      wait_boundary("div3_period", 20, n);
      check_eq("div3_period_edges", n, 3);
      do_load(8'd0);
      check_eq("ill0_cfg_err", cfg_err,     1);
      check_eq("ill0_pending", div_pending, 0);
      check_eq("ill0_active",  div_active,  3);

      // ---------------- reset mid-operation ----------------
      do_load(8'd9);
      wait_boundary("div9_swap", 20, n);
      check_eq("div9_active", div_active, 9);
      do_load(8'd5);
      check_eq("mid_pending_set", div_pending, 1);
      tick();
      check_eq("mid_clk_high_k2", clk_out, 1);
      rst = 1'b1;
      tick();
      check_eq("mid_rst_clk",     clk_out,      0);
      check_eq("mid_rst_pending", div_pending,  0);
      check_eq("mid_rst_active",  div_active,   4);
      check_eq("mid_rst_period",  period_count, 0);
      check_eq("mid_rst_strobe",  strobe,       0);
      @(negedge clk_in);
      #1;
      check_eq("mid_rst_clk_neg", clk_out, 0);
      tick();
      tick();
      rst = 1'b0;
      check_eq("mid_rel_period", period_count, 0);
      tick();
      check_eq("mid_rel_strobe", strobe,       1);
      check_eq("mid_rel_clk",    clk_out,      1);
      check_eq("mid_rel_period1", period_count, 1);
      wait_boundary("mid_rel_period", 20, n);
      check_eq("mid_rel_edges", n, 4);

      // ---------------- max divisor and wrap ----------------
      do_load(8'd255);
      wait_boundary("max_swap", 20, n);
      check_eq("max_active",     div_active, 255);
      check_eq("max_low_at_pos", clk_out,    0);
      highs     = 0;
      first_low = -1;
      for (int h = 0; h < 510; h++) begin
         if ((h % 2) == 0) begin
            @(negedge clk_in);
         end else begin
            @(posedge clk_in);
         end
         #1;
         if (clk_out === 1'b1) begin
            highs++;
         end else if (first_low < 0) begin
            first_low = h;
         end
      end
      check_eq("max_high_halves", highs,     255);
      check_eq("max_first_low",   first_low, 255);
      check_eq("max_strobe_end",  strobe,    1);
      pc0     = period_count;
      prev    = pc0;
      good    = 0;
      wrapped = 0;
      for (int p = 0; p < 256; p++) begin
         wait_boundary("max_period", 300, n);
         if (n == 255) begin
            good++;
         end
         if ((prev == 8'd255) && (period_count == 8'd0)) begin
            wrapped = 1;
         end
         prev = period_count;
      end
      check_eq("max_periods_255", good,         256);
      check_eq("max_wrap_seen",   wrapped,      1);
      check_eq("max_count_back",  period_count, pc0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
